// File: rtl/regs_pkg.sv
// Shared constants for the integer register file (regs).
// Mirrors the legacy ins_defines.v values so existing users keep the same names.
package regs_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [31:0] ZERO_WORD = 32'h0;
    localparam logic [REG_ADDR_W-1:0] x0 = 5'd0;

endpackage

// File: rtl/regs.sv
// Integer register file: x1..x(REG_NUM-1) in flops, x0 hard-wired to zero, two async read ports.
// Optional macro REGS_BYPASS_EN forwards a same-cycle write to a matching read port.
module regs
    import regs_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_NUM = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] reg1_raddr_i,
    input  logic [REG_ADDR_W-1:0] reg2_raddr_i,
    output logic [DATA_W-1:0]     reg1_rdata_o,
    output logic [DATA_W-1:0]     reg2_rdata_o,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic [DATA_W-1:0]     reg_wdata_i,
    input  logic                  reg_wen_i,
    input  logic                  hold_i
);

    // x0 deliberately has no entry in the array
    logic [DATA_W-1:0] regs_q [1:REG_NUM-1];
    logic              write_fire;

    always_comb begin
        write_fire = reg_wen_i && !hold_i && !rst
                     && (reg_waddr_i != x0)
                     && (32'(reg_waddr_i) < REG_NUM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_fire) begin
            regs_q[reg_waddr_i] <= reg_wdata_i;
        end
    end

    always_comb begin
        reg1_rdata_o = DATA_W'(ZERO_WORD);
        if ((reg1_raddr_i != x0) && (32'(reg1_raddr_i) < REG_NUM)) begin
`ifdef REGS_BYPASS_EN
            if (write_fire && (reg_waddr_i == reg1_raddr_i)) begin
                reg1_rdata_o = reg_wdata_i;
            end else begin
                reg1_rdata_o = regs_q[reg1_raddr_i];
            end
`else
            reg1_rdata_o = regs_q[reg1_raddr_i];
`endif
        end
    end

    always_comb begin
        reg2_rdata_o = DATA_W'(ZERO_WORD);
        if ((reg2_raddr_i != x0) && (32'(reg2_raddr_i) < REG_NUM)) begin
`ifdef REGS_BYPASS_EN
            if (write_fire && (reg_waddr_i == reg2_raddr_i)) begin
                reg2_rdata_o = reg_wdata_i;
            end else begin
                reg2_rdata_o = regs_q[reg2_raddr_i];
            end
`else
            reg2_rdata_o = regs_q[reg2_raddr_i];
`endif
        end
    end

endmodule

// File: tb/tb_regs.sv
// Self-checking bench for regs: expected read data is queued when stimulus is applied
// and popped when the read ports are sampled on the falling edge.
module tb_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  reg1_raddr_i, reg2_raddr_i, reg_waddr_i;
    logic [31:0] reg1_rdata_o, reg2_rdata_o, reg_wdata_i;
    logic        reg_wen_i, hold_i;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mdl [0:31];
    logic [31:0] exp;

    regs #(.DATA_W(32), .REG_NUM(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg1_raddr_i (reg1_raddr_i),
        .reg2_raddr_i (reg2_raddr_i),
        .reg1_rdata_o (reg1_rdata_o),
        .reg2_rdata_o (reg2_rdata_o),
        .reg_waddr_i  (reg_waddr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_wen_i    (reg_wen_i),
        .hold_i       (hold_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference read: stored model value, optionally overridden by a same-cycle write
    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'h0 : mdl[a];
`ifdef REGS_BYPASS_EN
        if (!rst && reg_wen_i && !hold_i && a != 5'd0 && a == reg_waddr_i)
            v = reg_wdata_i;
`endif
        return v;
    endfunction

    // Advance one clock, updating the model exactly as the register file should
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else if (reg_wen_i && !hold_i && reg_waddr_i != 5'd0) begin
            mdl[reg_waddr_i] = reg_wdata_i;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; reg_wen_i = 1'b0; hold_i = 1'b0;
        reg_waddr_i = 5'd0; reg_wdata_i = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; reg_wen_i = 1'b0; hold_i = 1'b0;
        reg_waddr_i = 5'd0; reg_wdata_i = 32'h0;
        reg1_raddr_i = 5'd1; reg2_raddr_i = 5'd31;
        tick(); tick();
        idle();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        exp = exp_q.pop_front(); checks++;
        if (reg1_rdata_o !== exp) begin errors++; $display("FAIL reset_x1: got %h want %h", reg1_rdata_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (reg2_rdata_o !== exp) begin errors++; $display("FAIL reset_x31: got %h want %h", reg2_rdata_o, exp); end
        // write x5, confirm it landed, then pulse reset
        reg_wen_i = 1'b1; reg_waddr_i = 5'd5; reg_wdata_i = 32'hDEAD_BEEF;
        tick();
        idle();
        reg1_raddr_i = 5'd5; reg2_raddr_i = 5'd31;
        exp_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        exp = exp_q.pop_front(); checks++;
        if (reg1_rdata_o !== exp) begin errors++; $display("FAIL pre_reset_x5: got %h want %h", reg1_rdata_o, exp); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        exp = exp_q.pop_front(); checks++;
        if (reg1_rdata_o !== exp) begin errors++; $display("FAIL post_reset_x5: got %h want %h", reg1_rdata_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (reg2_rdata_o !== exp) begin errors++; $display("FAIL post_reset_x31: got %h want %h", reg2_rdata_o, exp); end
    endtask

    task automatic test_x0();
        reg_wen_i = 1'b1; reg_waddr_i = 5'd0; reg_wdata_i = 32'h1234_5678;
        reg1_raddr_i = 5'd0; reg2_raddr_i = 5'd0;
        exp_q.push_back(32'h0);
        @(negedge clk);
        exp = exp_q.pop_front(); checks++;
        if (reg1_rdata_o !== exp) begin errors++; $display("FAIL x0_same_cycle: got %h want %h", reg1_rdata_o, exp); end
        tick();
        idle();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        exp = exp_q.pop_front(); checks++;
        if (reg1_rdata_o !== exp) begin errors++; $display("FAIL x0_after_write_p1: got %h want %h", reg1_rdata_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (reg2_rdata_o !== exp) begin errors++; $display("FAIL x0_after_write_p2: got %h want %h", reg2_rdata_o, exp); end
    endtask

    task automatic test_basic_write();
        reg_wen_i = 1'b1; reg_waddr_i = 5'd7; reg_wdata_i = 32'h0000_00AA;
        tick();
        idle();
        reg1_raddr_i = 5'd7; reg2_raddr_i = 5'd7;
        exp_q.push_back(32'hAA); exp_q.push_back(32'hAA);
        @(negedge clk);
        exp = exp_q.pop_front(); checks++;
        if (reg1_rdata_o !== exp) begin errors++; $display("FAIL write_x7_p1: got %h want %h", reg1_rdata_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (reg2_rdata_o !== exp) begin errors++; $display("FAIL write_x7_p2: got %h want %h", reg2_rdata_o, exp); end
    endtask

    task automatic test_bypass();
        reg_wen_i = 1'b1; reg_waddr_i = 5'd3; reg_wdata_i = 32'h55;
        reg1_raddr_i = 5'd3; reg2_raddr_i = 5'd3;
`ifdef REGS_BYPASS_EN
        exp_q.push_back(32'h55); exp_q.push_back(32'h55);
`else
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
`endif
        @(negedge clk);
        exp = exp_q.pop_front(); checks++;
        if (reg1_rdata_o !== exp) begin errors++; $display("FAIL bypass_p1: got %h want %h", reg1_rdata_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (reg2_rdata_o !== exp) begin errors++; $display("FAIL bypass_p2: got %h want %h", reg2_rdata_o, exp); end
        tick();
        idle();
        exp_q.push_back(32'h55);
        @(negedge clk);
        exp = exp_q.pop_front(); checks++;
        if (reg1_rdata_o !== exp) begin errors++; $display("FAIL bypass_next_cycle: got %h want %h", reg1_rdata_o, exp); end
    endtask

    task automatic test_hold();
        hold_i = 1'b1; reg_wen_i = 1'b1; reg_waddr_i = 5'd9; reg_wdata_i = 32'hFFFF_FFFF;
        reg1_raddr_i = 5'd9; reg2_raddr_i = 5'd9;
        exp_q.push_back(32'h0);
        @(negedge clk);
        exp = exp_q.pop_front(); checks++;
        if (reg1_rdata_o !== exp) begin errors++; $display("FAIL hold_no_bypass: got %h want %h", reg1_rdata_o, exp); end
        tick();
        idle();
        exp_q.push_back(32'h0);
        @(negedge clk);
        exp = exp_q.pop_front(); checks++;
        if (reg2_rdata_o !== exp) begin errors++; $display("FAIL hold_no_write: got %h want %h", reg2_rdata_o, exp); end
    endtask

    task automatic test_reset_priority();
        reg_wen_i = 1'b1; reg_waddr_i = 5'd4; reg_wdata_i = 32'h11;
        tick();
        rst = 1'b1; reg_wen_i = 1'b1; reg_waddr_i = 5'd4; reg_wdata_i = 32'h77;
        reg1_raddr_i = 5'd4; reg2_raddr_i = 5'd7;
        exp_q.push_back(32'h11);
        @(negedge clk);
        exp = exp_q.pop_front(); checks++;
        if (reg1_rdata_o !== exp) begin errors++; $display("FAIL rst_cycle_no_bypass: got %h want %h", reg1_rdata_o, exp); end
        tick();
        idle();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        exp = exp_q.pop_front(); checks++;
        if (reg1_rdata_o !== exp) begin errors++; $display("FAIL rst_priority_x4: got %h want %h", reg1_rdata_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (reg2_rdata_o !== exp) begin errors++; $display("FAIL rst_priority_x7: got %h want %h", reg2_rdata_o, exp); end
    endtask

    task automatic test_reset_midstream();
        for (int n = 0; n < 6; n++) begin
            rst = (n == 3);
            reg_wen_i = 1'b1; hold_i = 1'b0;
            reg_waddr_i = 5'(10 + n); reg_wdata_i = 32'hA000_0000 + 32'(n);
            tick();
        end
        idle();
        for (int n = 0; n < 6; n++) begin
            reg1_raddr_i = 5'(10 + n); reg2_raddr_i = 5'(10 + n);
            exp_q.push_back(model_read(reg1_raddr_i));
            @(negedge clk);
            exp = exp_q.pop_front(); checks++;
            if (reg1_rdata_o !== exp) begin
                errors++; $display("FAIL midstream_rst x%0d: got %h want %h", reg1_raddr_i, reg1_rdata_o, exp);
            end
            #1;
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            rst = 1'b0;
            reg_wen_i   = ($urandom_range(0, 3) != 0);
            hold_i      = ($urandom_range(0, 5) == 0);
            reg_waddr_i = 5'($urandom_range(0, 31));
            reg_wdata_i = $urandom;
            reg1_raddr_i = 5'($urandom_range(0, 31));
            reg2_raddr_i = (n % 4 == 0) ? reg_waddr_i : 5'($urandom_range(0, 31));
            exp_q.push_back(model_read(reg1_raddr_i));
            exp_q.push_back(model_read(reg2_raddr_i));
            @(negedge clk);
            exp = exp_q.pop_front(); checks++;
            if (reg1_rdata_o !== exp) begin
                errors++; $display("FAIL b2b_p1 x%0d: got %h want %h", reg1_raddr_i, reg1_rdata_o, exp);
            end
            exp = exp_q.pop_front(); checks++;
            if (reg2_rdata_o !== exp) begin
                errors++; $display("FAIL b2b_p2 x%0d: got %h want %h", reg2_raddr_i, reg2_rdata_o, exp);
            end
            tick();
        end
        idle();
        for (int a = 0; a < 32; a++) begin
            reg1_raddr_i = 5'(a); reg2_raddr_i = 5'(31 - a);
            exp_q.push_back(model_read(reg1_raddr_i));
            exp_q.push_back(model_read(reg2_raddr_i));
            @(negedge clk);
            exp = exp_q.pop_front(); checks++;
            if (reg1_rdata_o !== exp) begin
                errors++; $display("FAIL sweep_p1 x%0d: got %h want %h", reg1_raddr_i, reg1_rdata_o, exp);
            end
            exp = exp_q.pop_front(); checks++;
            if (reg2_rdata_o !== exp) begin
                errors++; $display("FAIL sweep_p2 x%0d: got %h want %h", reg2_raddr_i, reg2_rdata_o, exp);
            end
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        #1;
        test_reset();
        tick();
        test_x0();
        tick();
        test_basic_write();
        tick();
        test_bypass();
        tick();
        test_hold();
        tick();
        test_reset_priority();
        tick();
        test_reset_midstream();
        tick();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            errors++; checks++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
